// File: rtl/seq_pkg.sv
// Shared types for the sweep sequencer run controller.
package seq_pkg;

    localparam int NSTATES = 8;

    typedef enum logic [2:0] {
        STATE1 = 3'd0,
        STATE2 = 3'd1,
        STATE3 = 3'd2,
        STATE4 = 3'd3,
        STATE5 = 3'd4,
        STATE6 = 3'd5,
        STATE7 = 3'd6,
        STATE8 = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_e;

    // STATE8 wraps to STATE1.
    function automatic state_e next_state(input state_e s);
        logic [2:0] t;
        t = s + 3'd1;
        return state_e'(t);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_id
);

    int   idx;
    logic found;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/seq_run_ctrl.sv
// Shares the 8-state sweep sequencer between NREQ requesters, one windowed sweep at a time.
module seq_run_ctrl
    import seq_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int STATE_W = 3,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*STATE_W-1:0] req_first,
    input  logic [NREQ*STATE_W-1:0] req_last,
    input  logic                    hold,
    input  logic                    abort,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output state_e                  state,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic                    aborted
);

    ctrl_e           ctrl_q, ctrl_d;
    state_e          state_q, state_d;
    state_e          last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  wid_q, wid_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic            aborted_q, aborted_d;

    logic [NREQ-1:0] win;
    logic [IDW-1:0]  win_id;
    state_e          first_sel, last_sel;
    logic [IDW-1:0]  ptr_inc;
    logic            finish, finish_abort;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr_q),
        .win    (win),
        .win_id (win_id)
    );

    assign first_sel = state_e'(req_first[int'(win_id)*STATE_W +: STATE_W]);
    assign last_sel  = state_e'(req_last[int'(win_id)*STATE_W +: STATE_W]);
    assign ptr_inc   = (wid_q == IDW'(NREQ - 1)) ? '0 : wid_q + 1'b1;

    always_comb begin
        ctrl_d       = ctrl_q;
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        wid_d        = wid_q;
        rr_ptr_d     = rr_ptr_q;
        done_id_d    = done_id_q;
        aborted_d    = aborted_q;
        finish       = 1'b0;
        finish_abort = 1'b0;

        unique case (ctrl_q)
            IDLE: begin
                if (|req) begin
                    ctrl_d  = RUN;
                    gnt_d   = win;
                    state_d = first_sel;
                    last_d  = last_sel;
                    wid_d   = win_id;
                end
            end
            RUN: begin
                if (abort) begin
                    finish       = 1'b1;
                    finish_abort = 1'b1;
                end else if (hold) begin
                    state_d = state_q;
                end else if (state_q == last_q) begin
                    finish = 1'b1;
                end else begin
                    state_d = next_state(state_q);
                end
            end
            DONE: begin
                ctrl_d    = IDLE;
                aborted_d = 1'b0;
            end
            default: begin
                ctrl_d = IDLE;
            end
        endcase

        // Ending a sweep drops the grant and hands priority to the next requester.
        if (finish) begin
            ctrl_d    = DONE;
            gnt_d     = '0;
            done_id_d = wid_q;
            aborted_d = finish_abort;
            rr_ptr_d  = ptr_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= IDLE;
            state_q   <= STATE1;
            last_q    <= STATE1;
            gnt_q     <= '0;
            wid_q     <= '0;
            rr_ptr_q  <= '0;
            done_id_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            wid_q     <= wid_d;
            rr_ptr_q  <= rr_ptr_d;
            done_id_q <= done_id_d;
            aborted_q <= aborted_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (ctrl_q == RUN);
    assign done    = (ctrl_q == DONE);
    assign state   = state_q;
    assign done_id = done_id_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Scoreboard bench for seq_run_ctrl: stimulus queues expected RUN cycles and done events.
module tb_seq_run_ctrl;
    import seq_pkg::*;

    localparam int NREQ = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = '0;
    logic [5:0]    req_first = '0;
    logic [5:0]    req_last = '0;
    logic          hold = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    gnt;
    logic          busy;
    state_e        state;
    logic          done;
    logic [0:0]    done_id;
    logic          aborted;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] g;
        logic [2:0] st;
    } run_t;

    typedef struct {
        logic       id;
        logic       ab;
        logic [2:0] st;
    } done_t;

    run_t  run_q[$];
    done_t done_q[$];

    seq_run_ctrl #(
        .NREQ    (NREQ),
        .STATE_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_first (req_first),
        .req_last  (req_last),
        .hold      (hold),
        .abort     (abort),
        .gnt       (gnt),
        .busy      (busy),
        .state     (state),
        .done      (done),
        .done_id   (done_id),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endfunction

    function automatic logic [2:0] inc8(input logic [2:0] s);
        return s + 3'd1;
    endfunction

    // One queue entry per digit: the state expected on each RUN cycle.
    function automatic void push_run(input logic [1:0] g, input string s);
        for (int i = 0; i < s.len(); i++) begin
            run_q.push_back('{g: g, st: 3'(s[i] - 8'h30)});
        end
    endfunction

    function automatic void push_done(input logic id, input logic ab, input logic [2:0] st);
        done_q.push_back('{id: id, ab: ab, st: st});
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) begin
                if (run_q.size() == 0) begin
                    note_fail("run_unexpected");
                end else begin
                    run_t r;
                    r = run_q.pop_front();
                    check("run_gnt", 32'(gnt), 32'(r.g));
                    check("run_state", 32'(state), 32'(r.st));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    note_fail("done_unexpected");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_id", 32'(done_id), 32'(d.id));
                    check("done_aborted", 32'(aborted), 32'(d.ab));
                    check("done_state", 32'(state), 32'(d.st));
                    check("done_gnt", 32'(gnt), 32'd0);
                end
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt))
        else begin failures++; $display("FAIL assert_gnt_onehot0 gnt=%b", gnt); end

    a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done)
        else begin failures++; $display("FAIL assert_done_pulse done held"); end

    a_state_inc: assert property (@(posedge clk) disable iff (reset)
        ($past(busy) && !$past(hold) && !$past(abort) && ($past(state) != $past(dut.last_q)))
        |-> (busy && (3'(state) == inc8(3'($past(state))))))
        else begin failures++; $display("FAIL assert_state_inc state=%0d", state); end

    a_window: assert property (@(posedge clk) disable iff (reset)
        (busy && state == STATE7 && dut.last_q == STATE8 && $past(busy, 3) &&
         $past(state, 3) == STATE4 && !$past(hold, 1) && !$past(hold, 2) && !$past(hold, 3) &&
         !$past(abort, 1) && !$past(abort, 2) && !$past(abort, 3))
        |-> ($past(state, 2) == STATE5 && $past(state, 1) == STATE6))
        else begin failures++; $display("FAIL assert_window state=%0d", state); end

    // Request at a negedge; returns at the negedge of the first RUN cycle (index 0).
    task automatic start(input int id, input logic [2:0] f, input logic [2:0] l);
        @(negedge clk);
        req[id] = 1'b1;
        req_first[id*3 +: 3] = f;
        req_last[id*3 +: 3] = l;
        @(posedge clk);
        #1;
        check("grant_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req[id] = 1'b0;
    endtask

    task automatic sweep(input int id, input logic [2:0] f, input logic [2:0] l,
                         input int hold_at, input int hold_n, input int abort_at,
                         input int exp_lat);
        int lat;
        lat = -1;
        start(id, f, l);
        for (int i = 0; i < 40; i++) begin
            if (i == hold_at) hold = 1'b1;
            if (i == hold_at + hold_n) hold = 1'b0;
            abort = (i == abort_at);
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        hold = 1'b0;
        abort = 1'b0;
        check("done_latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic sweep 1..6 on requester 0
        push_run(2'b01, "123456");
        push_done(1'b0, 1'b0, 3'd6);
        sweep(0, 3'd1, 3'd6, -1, 0, -1, 6);

        // Wrap-around 6..1 on requester 1
        push_run(2'b10, "6701");
        push_done(1'b1, 1'b0, 3'd1);
        sweep(1, 3'd6, 3'd1, -1, 0, -1, 4);

        // Contention: both held across reset, single-state windows
        @(negedge clk);
        req = 2'b11;
        req_first = '0;
        req_last = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_run(2'b01, "0");
        push_done(1'b0, 1'b0, 3'd0);
        push_run(2'b10, "0");
        push_done(1'b1, 1'b0, 3'd0);
        push_run(2'b01, "0");
        push_done(1'b0, 1'b0, 3'd0);
        push_run(2'b10, "0");
        push_done(1'b1, 1'b0, 3'd0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("fair_busy", 32'(busy), 32'((k % 3) == 1));
            if (k == 10) req = 2'b00;
        end

        // Hold at state 4 for 3 cycles on window 2..7
        push_run(2'b01, "234444567");
        push_done(1'b0, 1'b0, 3'd7);
        sweep(0, 3'd2, 3'd7, 2, 3, -1, 9);

        // Abort at state 3 on window 0..7
        push_run(2'b10, "0123");
        push_done(1'b1, 1'b1, 3'd3);
        sweep(1, 3'd0, 3'd7, -1, 0, 3, 4);

        // Hold and abort together
        push_run(2'b01, "0123");
        push_done(1'b0, 1'b1, 3'd3);
        sweep(0, 3'd0, 3'd7, 3, 1, 3, 4);

        // Reset mid-run at state 5; rr_ptr was 1 and must return to 0
        push_run(2'b10, "2345");
        start(1, 3'd2, 3'd7);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        req = 2'b11;
        req_first = {3'd7, 3'd3};
        req_last = {3'd7, 3'd3};
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        push_run(2'b01, "3");
        push_done(1'b0, 1'b0, 3'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ptr_reset_gnt", 32'(gnt), 32'b01);
        @(negedge clk);
        req = 2'b00;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("post_rst_latency", 32'(lat), 32'd1);
        @(negedge clk);

        // Abort on the last state of window 4..5
        push_run(2'b10, "45");
        push_done(1'b1, 1'b1, 3'd5);
        sweep(1, 3'd4, 3'd5, -1, 0, 1, 2);

        repeat (3) @(negedge clk);
        check("run_q_empty", 32'(run_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_run_ctrl.md
# seq_run_ctrl

Round-robin scheduler that shares the 8-state sweep sequencer (`STATE1`..`STATE8`) between `NREQ` requesters. Each requester asks for a sweep over its own window `[first, last]`. The controller grants one requester at a time and drives the sequencer state through that window, one state per clock. It supports hold and abort, and signals completion with a one-cycle done pulse.

## Interface
- `NREQ`, default 2: number of requesters (2..4).
- `STATE_W`, default 3: width of the state encoding (fixed at 3, 8 states).

- `clk` in 1: single clock; all flops on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester sweep request; level, held until granted.
- `req_first` in NREQ*STATE_W: packed per-requester first state (slice i = requester i).
- `req_last` in NREQ*STATE_W: packed per-requester last state.
- `hold` in 1: freeze the state advance while in RUN.
- `abort` in 1: terminate the current sweep.
- `gnt` in/out: out, NREQ, one-hot grant, high for the whole sweep.
- `busy` out 1: FSM is in RUN.
- `state` out STATE_W: current sequencer state, type `state_e`.
- `done` out 1: one-cycle completion pulse.
- `done_id` out $clog2(NREQ): index of the requester whose sweep ended.
- `aborted` out 1: qualifies `done`; the sweep was aborted.

## Operation
- Encoding: `STATE1`=0 … `STATE8`=7.
- Controller FSM states are `IDLE`, `RUN` and `DONE`.
- **IDLE**
  - If any `req` bit is high: the round-robin arbiter picks a winner, searching upward from `rr_ptr` with wrap.
  - On that edge: `gnt[w]`=1, `state`=`req_first[w]` (latched), `last_q`=`req_last[w]`, go to RUN.
  - No request: `state` holds its value.
- **RUN**
  - Precedence: abort > hold > advance.
  - `abort`=1: go to DONE with `aborted`=1.
  - Else `hold`=1: `state` unchanged.
  - Else if `state`==`last_q`: go to DONE with `aborted`=0.
  - Else `state`=`state`+1, modulo 8 (`STATE8` wraps to `STATE1`).
- **DONE**
  - `done`=1, `gnt`=0, `done_id`=w, `state` holds.
  - `rr_ptr`=(w+1) mod NREQ.
  - Next edge: go to IDLE unconditionally.
- Sweep length is ((last−first) mod 8)+1 states, excluding hold cycles.
  - first==last gives one state.
  - last<first wraps through `STATE8`.
- `req`, `req_first`, `req_last` are sampled only at the IDLE grant edge. Changes during RUN are ignored.
- Dropping `req[w]` while granted has no effect. Only `abort` ends a sweep early.

## Timing
- Reset values: `state`=`STATE1`, `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `aborted`=0, `rr_ptr`=0, FSM=IDLE.
- Grant latency:
  - `req` high before edge N (FSM in IDLE) → after edge N, `gnt` and `busy` are high and `state`=first.
  - Each later edge advances one state.
- Run end:
  - The cycle showing `state`==last is the final RUN cycle.
  - The next edge enters DONE (`done`=1 for exactly one cycle).
  - The edge after that enters IDLE.
- Minimum spacing between two grants: first grant at edge N; next possible grant at edge N+L+2, where L is the sweep length.
- Simultaneous `abort` and `hold`: abort wins.
- `abort` on the cycle where `state`==last: DONE with `aborted`=1.
- Reset asserted mid-sweep: all outputs go to reset values immediately (asynchronous); no `done` pulse is issued.

## Structure
- Package `seq_pkg` holds:
  - `state_e` (`STATE1`..`STATE8`, 3-bit);
  - `ctrl_e` (`IDLE`, `RUN`, `DONE`);
  - `localparam NSTATES=8`.
- Sub-module `rr_arbiter`:
  - parameter NREQ;
  - inputs `req`, `ptr`;
  - outputs one-hot `win` and index `win_id`;
  - purely combinational.
- The FSM, window registers and `rr_ptr` live in `seq_run_ctrl`.
- Bind concurrent assertions in the bench:
  - `gnt` one-hot0;
  - `done` is a single-cycle pulse;
  - `state` increments by 1 mod 8 in RUN without hold;
  - the window check: sweep 3..6 occurs within sweep 2..7.

## Test plan
- **Basic sweep.** Reset, then `req[0]` with first=1, last=6 → `state` 1,2,3,4,5,6 on six consecutive cycles with `gnt`=01. Next cycle `done`=1, `done_id`=0, `aborted`=0; then IDLE.
- **Wrap-around.** `req[1]` with first=6, last=1 → `state` 6,7,0,1. Then `done` with `done_id`=1.
- **Contention and fairness.**
  - Both `req` bits held from reset, windows 0..0 → grants in order req0, req1, req0, req1.
  - Each grant arrives 3 cycles after the previous one (1-state sweep + DONE + IDLE).
- **Hold.** Window 2..7, `hold` high for 3 cycles while `state`=4 → `state` stays 4 for 4 cycles total. `done` arrives 3 cycles later than the unheld run.
- **Abort.**
  - Window 0..7, `abort` pulsed while `state`=3 → next cycle `done`=1, `aborted`=1, `state`=3.
  - Simultaneous `hold`+`abort` behaves the same way.
- **Reset mid-run.** Window 2..7, `reset` asserted while `state`=5 → `state`=0, `gnt`=0 and `busy`=0 immediately, with no `done`. After release, a pending `req` is granted normally, starting from `rr_ptr`=0.
